gradient_tile_scheduler: RTL and testbench
==========================================

Name: gradient_tile_scheduler

Overview:
Sequences the Sobel gradient datapath over a full frame held in an external pixel RAM. It walks the frame in 4x4 output tiles (6x6 input windows, stride 4, 2-pixel overlap) and fetches each window with one read per cycle. It then presents the window to the gradient block with a one-cycle win_valid, waits for that block's rdy, and hands the tile origin to the downstream corner-response stage through a valid/ready handshake.

Parameters:
IMG_W, 10, frame width in pixels; (IMG_W-2) must be a multiple of 4, and IMG_W >= 6
IMG_H, 10, frame height in pixels; (IMG_H-2) must be a multiple of 4, and IMG_H >= 6
ADDR_W, 16, pixel RAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
COORD_W, 10, width of tile origin coordinates

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle pulse that starts a frame pass; ignored while busy=1
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last tile is accepted downstream
rd_en  out  1  pixel RAM read strobe
rd_addr  out  ADDR_W  pixel RAM address, raster order, (y*IMG_W + x)
rd_data  in  8  pixel RAM data, valid exactly 1 cycle after rd_en
window  out  288  6x6 window; element [r][c] occupies bits [(r*6+c)*8 +: 8]
win_valid  out  1  one-cycle pulse: window is complete and stable
grad_rdy  in  1  gradient block has produced Gx/Gy for the issued window
tile_x  out  COORD_W  x origin of the current window's top-left pixel
tile_y  out  COORD_W  y origin of the current window's top-left pixel
tile_valid  out  1  Gx/Gy plus tile_x/tile_y are valid for downstream
tile_ready  in  1  downstream accepts the tile

Behaviour:
- Reset (reset=0, asynchronous) forces all outputs to 0, clears the window register to 0, and puts the FSM in IDLE. Reset in any state, including mid-FETCH, aborts the pass with no done pulse.
- FSM states and transitions:
  - IDLE: on start go to FETCH with tile_x=tile_y=0 and busy=1. In IDLE, rd_en, win_valid and tile_valid are all 0.
  - FETCH: 36 cycles. rd_en=1 each cycle, with addr=(tile_y+r)*IMG_W+tile_x+c. Order is r-major then c, each 0..5. Data returned one cycle later is written to window[r][c].
  - DRAIN: 1 cycle with rd_en=0; the last pixel, [5][5], lands here.
  - ISSUE: win_valid=1 for exactly one cycle. window is held constant from ISSUE until the tile handshake completes.
  - WAIT: stay until grad_rdy=1. A grad_rdy seen before ISSUE is ignored.
  - OUT: tile_valid=1 and tile_x/tile_y are stable. Stay until tile_valid&&tile_ready. On that handshake:
    - advance tile_x by 4;
    - when tile_x+4 > IMG_W-6, wrap tile_x to 0 and add 4 to tile_y;
    - when tile_y+4 > IMG_H-6 as well, go to FIN; otherwise go to FETCH.
  - FIN: done=1 and busy=0 for 1 cycle, then IDLE.
- Minimum tile period is 40 cycles (36+1+1+1+1) when grad_rdy and tile_ready are 1 immediately.
- No read is issued outside FETCH. Under backpressure in WAIT or OUT, rd_en stays 0.
- A start pulse that coincides with FIN or arrives in any busy state is dropped. A start in the cycle after FIN (IDLE) is accepted.
- Address arithmetic is unsigned. A multiply by the constant IMG_W is permitted, but an incremental row-base register is preferred.
- The tile grid is (IMG_W-2)/4 columns by (IMG_H-2)/4 rows. The default grid is 2x2, i.e. 4 tiles.

Decomposition:
- Shared package grad_pkg holds:
  - the FSM state enum (IDLE, FETCH, DRAIN, ISSUE, WAIT, OUT, FIN);
  - WIN_N=6, TILE_N=4, STRIDE=4, PIX_W=8;
  - the window flattening helper (index function).
- One sub-module, window_fetch_addr_gen, is natural. It holds the r/c counters and the row base, and produces rd_addr, the write index and the last-read flag. The top level keeps the FSM, window register and tile counters.

Test Plan:
1. Default 10x10 frame, RAM pixel = addr%256, grad_rdy tied 1, tile_ready tied 1, start at cycle 5. Required:
   - origins (0,0),(4,0),(0,4),(4,4) in that order;
   - tile0 window[0][0]=0, [0][5]=5, [5][5]=55;
   - tile1 [0][0]=4;
   - tile3 [0][0]=44;
   - done one cycle after the 4th handshake;
   - exactly 144 rd_en cycles.
2. Backpressure: hold tile_ready=0 for 7 cycles in tile0 OUT. Required: tile_valid stays 1, tile_x/tile_y and window stay unchanged, rd_en=0 throughout, and the tile1 FETCH starts the cycle after tile_ready rises.
3. Slow gradient: grad_rdy asserted 5 cycles after win_valid, plus a spurious grad_rdy pulse during FETCH. Required: win_valid is exactly 1 cycle wide, the FSM leaves WAIT only on the post-ISSUE grad_rdy, and the spurious pulse has no effect.
4. Reset mid-operation: drive reset=0 at FETCH index 20 of tile2. Required: all outputs are 0 immediately (asynchronous), there is no done pulse, and after reset=1 plus start the pass restarts at (0,0).
5. start handling: start pulses during FETCH, OUT and FIN are ignored, so exactly one done pulse occurs. A start one cycle after done begins a new pass with busy=1.
6. Non-default 14x6 frame (IMG_W=14, IMG_H=6). Required: 3 tiles at (0,0),(4,0),(8,0); tile2 [5][5]=5*14+13=83.

Source files
------------

// File: rtl/grad_pkg.sv
// Shared constants, FSM encoding and window flattening helper for the
// gradient tile scheduler slice.
package grad_pkg;
  localparam int WIN_N    = 6;
  localparam int TILE_N   = 4;
  localparam int STRIDE   = 4;
  localparam int PIX_W    = 8;
  localparam int WIN_PIX  = WIN_N * WIN_N;
  localparam int WIN_BITS = WIN_PIX * PIX_W;

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, ISSUE, WAIT, OUT, FIN
  } state_t;

  // Flat element index of window[r][c]; element occupies bits [idx*PIX_W +: PIX_W].
  function automatic logic [5:0] win_idx(input logic [2:0] r, input logic [2:0] c);
    return 6'(r) * 6'(WIN_N) + 6'(c);
  endfunction
endpackage

// File: rtl/window_fetch_addr_gen.sv
// Row/column walker for one 6x6 window fetch: raster address, flat write
// index and last-read flag. Counters clear whenever the fetch is idle.
module window_fetch_addr_gen
  import grad_pkg::*;
#(
  parameter int IMG_W  = 10,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] addr,
  output logic [5:0]        idx,
  output logic              last
);
  logic [2:0]        r, c;
  logic [ADDR_W-1:0] row_off;

  // row_off tracks r*IMG_W incrementally so no multiplier is needed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r       <= '0;
      c       <= '0;
      row_off <= '0;
    end else if (!en) begin
      r       <= '0;
      c       <= '0;
      row_off <= '0;
    end else if (c == 3'(WIN_N-1)) begin
      c       <= '0;
      r       <= r + 3'd1;
      row_off <= row_off + ADDR_W'(IMG_W);
    end else begin
      c <= c + 3'd1;
    end
  end

  assign addr = base + row_off + ADDR_W'(c);
  assign idx  = win_idx(r, c);
  assign last = (r == 3'(WIN_N-1)) && (c == 3'(WIN_N-1));
endmodule

// File: rtl/gradient_tile_scheduler.sv
// Walks a frame in 4x4 output tiles: fetches each 6x6 window from pixel RAM,
// issues it to the gradient block, then hands the tile origin downstream.
module gradient_tile_scheduler
  import grad_pkg::*;
#(
  parameter int IMG_W   = 10,
  parameter int IMG_H   = 10,
  parameter int ADDR_W  = 16,
  parameter int COORD_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [7:0]          rd_data,
  output logic [WIN_BITS-1:0] window,
  output logic                win_valid,
  input  logic                grad_rdy,
  output logic [COORD_W-1:0]  tile_x,
  output logic [COORD_W-1:0]  tile_y,
  output logic                tile_valid,
  input  logic                tile_ready
);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(IMG_W - WIN_N);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(IMG_H - WIN_N);
  localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(STRIDE * IMG_W);

  state_t            st, st_nxt;
  logic [ADDR_W-1:0] tile_base, tile_row, fetch_addr;
  logic [5:0]        fetch_idx, wr_idx;
  logic              fetch_last, wr_vld, hs, col_wrap, row_wrap;

  // origins step by STRIDE, so equality with the last origin is the wrap test
  assign col_wrap = (tile_x == X_LAST);
  assign row_wrap = (tile_y == Y_LAST);
  assign hs       = tile_valid && tile_ready;

  window_fetch_addr_gen #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) u_ag (
    .clk  (clk),
    .reset(reset),
    .en   (rd_en),
    .base (tile_base),
    .addr (fetch_addr),
    .idx  (fetch_idx),
    .last (fetch_last)
  );

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:    if (start) st_nxt = FETCH;
      FETCH:   if (fetch_last) st_nxt = DRAIN;
      DRAIN:   st_nxt = ISSUE;
      ISSUE:   st_nxt = WAIT;
      WAIT:    if (grad_rdy) st_nxt = OUT;
      OUT:     if (tile_ready) st_nxt = (col_wrap && row_wrap) ? FIN : FETCH;
      FIN:     st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= IDLE;
    else        st <= st_nxt;
  end

  // tile_base = tile_row + tile_x, tile_row = tile_y*IMG_W, both kept incrementally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tile_x    <= '0;
      tile_y    <= '0;
      tile_base <= '0;
      tile_row  <= '0;
    end else if (st == IDLE && start) begin
      tile_x    <= '0;
      tile_y    <= '0;
      tile_base <= '0;
      tile_row  <= '0;
    end else if (hs) begin
      if (col_wrap) begin
        tile_x    <= '0;
        tile_y    <= tile_y + COORD_W'(STRIDE);
        tile_row  <= tile_row + ROW_STEP;
        tile_base <= tile_row + ROW_STEP;
      end else begin
        tile_x    <= tile_x + COORD_W'(STRIDE);
        tile_base <= tile_base + ADDR_W'(STRIDE);
      end
    end
  end

  // RAM data trails the strobe by one cycle; writes stop after DRAIN,
  // so the window is stable from ISSUE through the tile handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      window <= '0;
      wr_vld <= 1'b0;
      wr_idx <= '0;
    end else begin
      wr_vld <= rd_en;
      wr_idx <= fetch_idx;
      if (wr_vld) window[{wr_idx, 3'b000} +: PIX_W] <= rd_data;
    end
  end

  assign rd_en      = (st == FETCH);
  assign rd_addr    = rd_en ? fetch_addr : '0;
  assign win_valid  = (st == ISSUE);
  assign tile_valid = (st == OUT);
  assign done       = (st == FIN);
  assign busy       = (st != IDLE) && (st != FIN);
endmodule

// File: tb/tb_gradient_tile_scheduler.sv
// Directed bench for gradient_tile_scheduler: default 10x10 frame plus a
// 14x6 instance, with a RAM model returning addr%256.
module tb_gradient_tile_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 10x10 instance
  logic         reset, start, grad_rdy, tile_ready;
  logic         busy, done, rd_en, win_valid, tile_valid;
  logic [15:0]  rd_addr;
  logic [7:0]   rd_data = 8'd0;
  logic [287:0] window;
  logic [9:0]   tile_x, tile_y;

  gradient_tile_scheduler #(.IMG_W(10), .IMG_H(10), .ADDR_W(16), .COORD_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .window(window),
    .win_valid(win_valid), .grad_rdy(grad_rdy), .tile_x(tile_x), .tile_y(tile_y),
    .tile_valid(tile_valid), .tile_ready(tile_ready)
  );

  always @(posedge clk) rd_data <= rd_addr[7:0];

  // 14x6 instance
  logic         reset2, start2, grad_rdy2, tile_ready2;
  logic         busy2, done2, rd_en2, win_valid2, tile_valid2;
  logic [15:0]  rd_addr2;
  logic [7:0]   rd_data2 = 8'd0;
  logic [287:0] window2;
  logic [9:0]   tile_x2, tile_y2;

  gradient_tile_scheduler #(.IMG_W(14), .IMG_H(6), .ADDR_W(16), .COORD_W(10)) dut2 (
    .clk(clk), .reset(reset2), .start(start2), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .window(window2),
    .win_valid(win_valid2), .grad_rdy(grad_rdy2), .tile_x(tile_x2), .tile_y(tile_y2),
    .tile_valid(tile_valid2), .tile_ready(tile_ready2)
  );

  always @(posedge clk) rd_data2 <= rd_addr2[7:0];

  // Monitors: event counters only ever grow; tests work with deltas.
  int           cyc = 0, rd_cnt = 0, hs_cnt = 0, done_cnt = 0, done_cyc = 0;
  int           hs_cyc [64];
  logic [9:0]   hs_x [64];
  logic [9:0]   hs_y [64];
  logic [287:0] hs_win [64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_cnt <= rd_cnt + 1;
    if (tile_valid && tile_ready && hs_cnt < 64) begin
      hs_x[hs_cnt]   <= tile_x;
      hs_y[hs_cnt]   <= tile_y;
      hs_win[hs_cnt] <= window;
      hs_cyc[hs_cnt] <= cyc;
      hs_cnt         <= hs_cnt + 1;
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  int           rd_cnt2 = 0, hs_cnt2 = 0, done_cnt2 = 0;
  logic [9:0]   hs2_x [8];
  logic [9:0]   hs2_y [8];
  logic [287:0] hs2_win [8];

  always @(posedge clk) begin
    if (rd_en2) rd_cnt2 <= rd_cnt2 + 1;
    if (tile_valid2 && tile_ready2 && hs_cnt2 < 8) begin
      hs2_x[hs_cnt2]   <= tile_x2;
      hs2_y[hs_cnt2]   <= tile_y2;
      hs2_win[hs_cnt2] <= window2;
      hs_cnt2          <= hs_cnt2 + 1;
    end
    if (done2) done_cnt2 <= done_cnt2 + 1;
  end

  function automatic logic [7:0] pix(input logic [287:0] w, input int r, input int c);
    return w[(r*6+c)*8 +: 8];
  endfunction

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; reset2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, rd_en, win_valid, tile_valid} !== 5'b0 || rd_addr !== 16'd0 ||
        tile_x !== 10'd0 || tile_y !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b rd_en=%b win_valid=%b tile_valid=%b rd_addr=%0d tile=(%0d,%0d), want all 0",
               busy, done, rd_en, win_valid, tile_valid, rd_addr, tile_x, tile_y);
    end
    checks++;
    if (window !== 288'd0) begin
      errors++;
      $display("FAIL reset_window: window=%h, want 0", window);
    end
    reset = 1'b1; reset2 = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b rd_en=%b, want 0 0", busy, rd_en);
    end
  endtask

  task automatic test_full_frame;
    int h0, r0, d0;
    bit ok;
    h0 = hs_cnt; r0 = rd_cnt; d0 = done_cnt;
    grad_rdy = 1'b1; tile_ready = 1'b1;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr !== 16'd0) begin
      errors++;
      $display("FAIL start_fetch: busy=%b rd_en=%b rd_addr=%0d, want 1 1 0", busy, rd_en, rd_addr);
    end
    wait_done(d0 + 1, 400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_done_timeout: no done within 400 cycles");
    end
    checks++;
    if (hs_cnt - h0 !== 4) begin
      errors++;
      $display("FAIL tile_count: got %0d, want 4", hs_cnt - h0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hs_x[h0+i] !== 10'((i % 2) * 4) || hs_y[h0+i] !== 10'((i / 2) * 4)) begin
        errors++;
        $display("FAIL origin%0d: got (%0d,%0d), want (%0d,%0d)", i, hs_x[h0+i], hs_y[h0+i], (i%2)*4, (i/2)*4);
      end
    end
    checks++;
    if (pix(hs_win[h0], 0, 0) !== 8'd0 || pix(hs_win[h0], 0, 5) !== 8'd5 || pix(hs_win[h0], 5, 5) !== 8'd55) begin
      errors++;
      $display("FAIL tile0_pixels: [0][0]=%0d [0][5]=%0d [5][5]=%0d, want 0 5 55",
               pix(hs_win[h0], 0, 0), pix(hs_win[h0], 0, 5), pix(hs_win[h0], 5, 5));
    end
    checks++;
    if (pix(hs_win[h0+1], 0, 0) !== 8'd4) begin
      errors++;
      $display("FAIL tile1_pixel: [0][0]=%0d, want 4", pix(hs_win[h0+1], 0, 0));
    end
    checks++;
    if (pix(hs_win[h0+3], 0, 0) !== 8'd44 || pix(hs_win[h0+3], 5, 5) !== 8'd99) begin
      errors++;
      $display("FAIL tile3_pixels: [0][0]=%0d [5][5]=%0d, want 44 99", pix(hs_win[h0+3], 0, 0), pix(hs_win[h0+3], 5, 5));
    end
    checks++;
    if (done_cyc !== hs_cyc[h0+3] + 1) begin
      errors++;
      $display("FAIL done_timing: done at %0d, last handshake at %0d, want +1", done_cyc, hs_cyc[h0+3]);
    end
    checks++;
    if (hs_cyc[h0+1] - hs_cyc[h0] !== 40) begin
      errors++;
      $display("FAIL tile_period: got %0d, want 40", hs_cyc[h0+1] - hs_cyc[h0]);
    end
    checks++;
    if (rd_cnt - r0 !== 144) begin
      errors++;
      $display("FAIL read_count: got %0d, want 144", rd_cnt - r0);
    end
  endtask

  task automatic test_backpressure;
    int h0, d0;
    bit ok, bad;
    logic [287:0] snap;
    h0 = hs_cnt; d0 = done_cnt;
    grad_rdy = 1'b1; tile_ready = 1'b0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tile_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_tile_valid_timeout: tile_valid never rose");
    end
    snap = window;
    bad = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (tile_valid !== 1'b1 || tile_x !== 10'd0 || tile_y !== 10'd0 || rd_en !== 1'b0 || window !== snap) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad || tile_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: tile_valid=%b tile=(%0d,%0d) rd_en=%b during stall, want 1 (0,0) 0, window held",
               tile_valid, tile_x, tile_y, rd_en);
    end
    tile_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== 16'd4 || tile_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_fetch: rd_en=%b rd_addr=%0d tile_valid=%b, want 1 4 0", rd_en, rd_addr, tile_valid);
    end
    wait_done(d0 + 1, 400, ok);
    checks++;
    if (!ok || hs_cnt - h0 !== 4 || hs_x[h0+1] !== 10'd4 || hs_y[h0+1] !== 10'd0) begin
      errors++;
      $display("FAIL bp_frame: done=%b tiles=%0d tile1=(%0d,%0d), want 1 4 (4,0)", ok, hs_cnt - h0, hs_x[h0+1], hs_y[h0+1]);
    end
  endtask

  task automatic test_slow_grad;
    int h0, d0;
    bit ok, bad;
    h0 = hs_cnt; d0 = done_cnt;
    grad_rdy = 1'b0; tile_ready = 1'b1;
    pulse_start();
    repeat (10) @(negedge clk);
    grad_rdy = 1'b1;
    @(negedge clk);
    grad_rdy = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (win_valid === 1'b1) begin ok = 1'b1; break; end
      if (tile_valid === 1'b1) break;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sg_win_valid_timeout: win_valid not seen before tile_valid");
    end
    bad = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (win_valid !== 1'b0 || tile_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL sg_wait: win_valid=%b tile_valid=%b while grad_rdy low, want 0 0", win_valid, tile_valid);
    end
    grad_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (tile_valid !== 1'b1) begin
      errors++;
      $display("FAIL sg_out: tile_valid=%b after grad_rdy, want 1", tile_valid);
    end
    wait_done(d0 + 1, 400, ok);
    checks++;
    if (!ok || hs_cnt - h0 !== 4 || pix(hs_win[h0], 5, 5) !== 8'd55) begin
      errors++;
      $display("FAIL sg_frame: done=%b tiles=%0d tile0[5][5]=%0d, want 1 4 55", ok, hs_cnt - h0, pix(hs_win[h0], 5, 5));
    end
  endtask

  task automatic test_reset_mid;
    int h0, d0, h1;
    bit ok;
    h0 = hs_cnt; d0 = done_cnt;
    grad_rdy = 1'b1; tile_ready = 1'b1;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (hs_cnt - h0 >= 2 && rd_en === 1'b1 && rd_addr === 16'd72) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rm_locate: tile2 fetch index 20 (addr 72) not reached");
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, rd_en, win_valid, tile_valid} !== 5'b0 || rd_addr !== 16'd0 ||
        tile_x !== 10'd0 || tile_y !== 10'd0 || window !== 288'd0) begin
      errors++;
      $display("FAIL rm_async_clear: busy=%b rd_en=%b rd_addr=%0d tile=(%0d,%0d), want all 0", busy, rd_en, rd_addr, tile_x, tile_y);
    end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rm_no_done: done pulses=%0d busy=%b, want 0 0", done_cnt - d0, busy);
    end
    h1 = hs_cnt;
    pulse_start();
    checks++;
    if (rd_en !== 1'b1 || rd_addr !== 16'd0) begin
      errors++;
      $display("FAIL rm_restart_addr: rd_en=%b rd_addr=%0d, want 1 0", rd_en, rd_addr);
    end
    wait_done(d0 + 1, 400, ok);
    checks++;
    if (!ok || hs_x[h1] !== 10'd0 || hs_y[h1] !== 10'd0) begin
      errors++;
      $display("FAIL rm_restart_origin: done=%b first=(%0d,%0d), want 1 (0,0)", ok, hs_x[h1], hs_y[h1]);
    end
  endtask

  task automatic test_start_handling;
    int h0, d0;
    bit ok;
    h0 = hs_cnt; d0 = done_cnt;
    grad_rdy = 1'b1; tile_ready = 1'b1;
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 100 && tile_valid !== 1'b1; i++) @(negedge clk);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    pulse_start();
    checks++;
    if (!ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL sh_fin_start: done seen=%b busy after FIN=%b, want 1 0", ok, busy);
    end
    repeat (50) @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1 || hs_cnt - h0 !== 4 || busy !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL sh_single_pass: done pulses=%0d tiles=%0d busy=%b rd_en=%b, want 1 4 0 0",
               done_cnt - d0, hs_cnt - h0, busy, rd_en);
    end
    d0 = done_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    pulse_start();
    checks++;
    if (!ok || busy !== 1'b1) begin
      errors++;
      $display("FAIL sh_restart_after_done: done seen=%b busy=%b, want 1 1", ok, busy);
    end
    wait_done(d0 + 2, 400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sh_second_pass: done pulses=%0d, want 2", done_cnt - d0);
    end
  endtask

  task automatic test_wide_frame;
    bit ok;
    grad_rdy2 = 1'b1; tile_ready2 = 1'b1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_cnt2 >= 1) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || hs_cnt2 !== 3) begin
      errors++;
      $display("FAIL wide_tiles: done=%b tiles=%0d, want 1 3", ok, hs_cnt2);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hs2_x[i] !== 10'(i * 4) || hs2_y[i] !== 10'd0) begin
        errors++;
        $display("FAIL wide_origin%0d: got (%0d,%0d), want (%0d,0)", i, hs2_x[i], hs2_y[i], i * 4);
      end
    end
    checks++;
    if (pix(hs2_win[2], 5, 5) !== 8'd83 || pix(hs2_win[2], 0, 0) !== 8'd8) begin
      errors++;
      $display("FAIL wide_tile2_pixels: [5][5]=%0d [0][0]=%0d, want 83 8", pix(hs2_win[2], 5, 5), pix(hs2_win[2], 0, 0));
    end
    checks++;
    if (rd_cnt2 !== 108) begin
      errors++;
      $display("FAIL wide_read_count: got %0d, want 108", rd_cnt2);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; grad_rdy = 1'b1; tile_ready = 1'b1;
    reset2 = 1'b0; start2 = 1'b0; grad_rdy2 = 1'b1; tile_ready2 = 1'b1;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_slow_grad();
    test_reset_mid();
    test_start_handling();
    test_wide_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
